// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between an instruction-fetch requester
//               (read-only) and a data-memory requester. Round-robin grant on
//               contention, one outstanding transaction, sticky timeout error,
//               pipeline stall request and a 16-bit completion counter.
// Ports       : cclk/rst           - clock, synchronous active-low reset
//               if_*               - fetch requester (req/addr in, rdata/valid out)
//               dm_*               - data requester (req/we/addr/wdata in, rdata/valid out)
//               mem_*              - shared memory port (req/we/addr/wdata out, rdata/ack in)
//               pipe_stall         - combinational freeze request to the pipeline
//               err                - sticky timeout flag, cleared only by reset
//               xact_cnt           - completed-transaction count, wraps silently
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              cclk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              pipe_stall,
    output logic              err,
    output logic [15:0]       xact_cnt
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_busy_if = 2'd1;
    localparam logic [1:0] c_busy_dm = 2'd2;
    localparam logic [1:0] c_err     = 2'd3;

    // Wait-counter value at which one more ack-less BUSY cycle reaches TIMEOUT.
    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(TIMEOUT - 1);

    logic [1:0]        state_q,     state_d;
    logic              rr_dm_q,     rr_dm_d;     // 1: DM wins the next contention
    logic [CNT_W-1:0]  wait_q,      wait_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic              mem_we_q,    mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       if_rdata_q,  if_rdata_d;
    logic [31:0]       dm_rdata_q,  dm_rdata_d;
    logic              if_valid_q,  if_valid_d;
    logic              dm_valid_q,  dm_valid_d;
    logic [15:0]       xact_q,      xact_d;

    logic if_elig;
    logic dm_elig;
    logic grant_if;
    logic grant_dm;

    // A requester whose valid is high this cycle is still holding the req of
    // the transaction just completed; it must not be re-granted on it.
    assign if_elig  = if_req & ~if_valid_q;
    assign dm_elig  = dm_req & ~dm_valid_q;
    assign grant_dm = dm_elig & (~if_elig | rr_dm_q);
    assign grant_if = if_elig & ~grant_dm;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge cclk) begin
        if (!rst) begin
            state_q     <= c_idle;
            rr_dm_q     <= 1'b1;
            wait_q      <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            xact_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_dm_q     <= rr_dm_d;
            wait_q      <= wait_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            xact_q      <= xact_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_dm_d     = rr_dm_q;
        wait_d      = wait_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        xact_d      = xact_q;

        case (state_q)
            c_idle: begin
                if (grant_dm) begin
                    state_d     = c_busy_dm;
                    mem_addr_d  = dm_addr;
                    mem_we_d    = dm_we;
                    mem_wdata_d = dm_wdata;
                    wait_d      = '0;
                    rr_dm_d     = 1'b0;
                end else if (grant_if) begin
                    state_d     = c_busy_if;
                    mem_addr_d  = if_addr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    wait_d      = '0;
                    rr_dm_d     = 1'b1;
                end
            end
            c_busy_if, c_busy_dm: begin
                // An ack in the cycle the timeout would trip takes priority.
                if (mem_ack) begin
                    state_d = c_idle;
                    xact_d  = xact_q + 16'd1;
                    if (state_q == c_busy_if) begin
                        if_rdata_d = mem_rdata;
                        if_valid_d = 1'b1;
                    end else begin
                        dm_rdata_d = mem_rdata;
                        dm_valid_d = 1'b1;
                    end
                end else if (wait_q == c_wait_last) begin
                    state_d = c_err;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = c_err;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        mem_req    = (state_q == c_busy_if) || (state_q == c_busy_dm);
        err        = (state_q == c_err);
        pipe_stall = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q) | err;
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign xact_cnt  = xact_q;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width of both requesters and the memory port.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of BUSY cycles without mem_ack before the error state.
REQ-003 The block SHALL have port cclk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-005 The block SHALL have ports if_req  input  1, if_addr  input  ADDR_W, if_rdata  output  32 and if_valid  output  1, forming the instruction-fetch requester (read-only).
REQ-006 The block SHALL have ports dm_req  input  1, dm_we  input  1, dm_addr  input  ADDR_W, dm_wdata  input  32, dm_rdata  output  32 and dm_valid  output  1, forming the data-memory requester.
REQ-007 The block SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  ADDR_W, mem_wdata  output  32, mem_rdata  input  32 and mem_ack  input  1, forming the single shared memory port.
REQ-008 The block SHALL have port pipe_stall  output  1  pipeline freeze request.
REQ-009 The block SHALL have port err  output  1  sticky memory-timeout flag.
REQ-010 The block SHALL have port xact_cnt  output  16  count of completed transactions.

Function
REQ-011 The FSM SHALL have states IDLE, BUSY_IF, BUSY_DM and ERR.
REQ-012 In IDLE, with only dm_req eligible, the FSM SHALL go to BUSY_DM; with only if_req eligible, it SHALL go to BUSY_IF; with neither eligible, it SHALL stay in IDLE.
REQ-013 When both requesters are eligible in IDLE, the FSM SHALL grant round-robin: the requester not granted last wins; the first contention after reset goes to DM.
REQ-014 A requester SHALL be ineligible in the cycle its own valid is high, so that no re-grant occurs before it drops or renews req.
REQ-015 On a grant, the FSM SHALL register mem_addr, mem_we (0 for IF, dm_we for DM) and mem_wdata from the granted requester; these SHALL stay stable while in BUSY.
REQ-016 mem_req SHALL be 1 exactly while the state is BUSY_IF or BUSY_DM, starting the cycle after the grant decision.
REQ-017 Requesters SHALL hold req, addr, we and wdata stable from assertion until their valid pulse.
REQ-018 On mem_ack in BUSY_x, the FSM SHALL register mem_rdata into x_rdata, pulse x_valid high for exactly one cycle (the cycle after ack), increment xact_cnt and return to IDLE.
REQ-019 Minimum latency from req sampled to valid SHALL be 2 cycles (grant edge, then ack seen on the first BUSY cycle); there SHALL be no back-to-back grant without an IDLE cycle.
REQ-020 x_rdata SHALL hold its value until the next completion for that requester; on DM writes, dm_rdata SHALL take mem_rdata as-is.
REQ-021 mem_ack in IDLE or ERR SHALL be ignored.
REQ-022 A wait counter SHALL clear on entering BUSY and increment on each BUSY cycle without ack; when it reaches TIMEOUT without ack, the FSM SHALL go to ERR.
REQ-023 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, no ERR.
REQ-024 In ERR: mem_req = 0, no grants, no valid pulses, err = 1; the block SHALL leave ERR only by reset.
REQ-025 pipe_stall SHALL be combinational and equal (if_req & ~if_valid) | (dm_req & ~dm_valid) | err.
REQ-026 xact_cnt SHALL be 16-bit and wrap from 0xFFFF to 0x0000 without flagging.

Reset
REQ-027 When rst = 0 at a rising edge, the next state SHALL be IDLE, and mem_req, mem_we, if_valid, dm_valid and err SHALL all be 0.
REQ-028 The same reset SHALL clear mem_addr, mem_wdata, if_rdata, dm_rdata and xact_cnt to 0, and point the round-robin at DM.
REQ-029 Reset mid-transaction SHALL abandon it: no valid pulse and no count increment; a late mem_ack after reset SHALL be ignored.

Verification
REQ-030 Single fetch: if_req = 1, if_addr = 0x40, and memory acks on the first BUSY cycle with 0x8C220004 -> mem_req high for 1 cycle, if_valid pulse with if_rdata = 0x8C220004 two cycles after req, xact_cnt = 1.
REQ-031 Contention: if_req and dm_req both rise in the same cycle (dm_we = 1, dm_addr = 0x100, dm_wdata = 0xDEADBEEF) -> DM is served first with mem_we = 1, then IF; pipe_stall stays 1 until if_valid.
REQ-032 Round-robin: both requesters are held continuously, renewing after each valid, across 4 transactions -> grant order DM, IF, DM, IF.
REQ-033 Timeout: dm_req with no mem_ack for 15 BUSY cycles -> ERR, err = 1, mem_req = 0, pipe_stall = 1; later requests are ignored until rst = 0.
REQ-034 Boundary: mem_ack arrives on exactly the 15th wait cycle -> normal completion with err = 0; also, 65536 completions -> xact_cnt = 0x0000.
REQ-035 Reset during BUSY_IF with mem_ack arriving one cycle later -> IDLE, if_valid stays 0, xact_cnt stays 0.
